// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot column drive, settled row sampling, per-key
// debounce, and a show-ahead press/release event FIFO.
module keypad_scan_ctrl #(
    parameter int unsigned NCOLS          = 2,
    parameter int unsigned NROWS          = 2,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     scan_en,
    input  logic [NROWS-1:0]         row_in,
    output logic [NCOLS-1:0]         col_out,
    output logic [NCOLS*NROWS-1:0]   key_state,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [3:0]               evt_key,
    output logic                     evt_press,
    output logic                     overflow
);

    localparam int unsigned NKEYS = NCOLS * NROWS;
    localparam int unsigned CW    = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int unsigned RW    = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int unsigned SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned NW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EVAL  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   col_idx, col_n;
    logic [RW-1:0]   row_idx, row_n;
    logic [SW-1:0]   settle_cnt, settle_n;
    logic            eval_en;

    logic [NROWS-1:0] row_meta, row_sync;

    logic [3:0]      dbc_cnt [NKEYS];
    logic [3:0]      cur_key;
    logic [3:0]      cur_cnt;
    logic [3:0]      cnt_inc;
    logic            cur_state;
    logic            sample;
    logic            differ;
    logic            push;

    logic [3:0]      fifo_key   [FIFO_DEPTH];
    logic            fifo_press [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   fcount;
    logic            pop;
    logic            push_ok;

    always_ff @(posedge CLK) begin
        if (RST) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            col_idx    <= '0;
            row_idx    <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_n;
            col_idx    <= col_n;
            row_idx    <= row_n;
            settle_cnt <= settle_n;
        end
    end

    always_comb begin
        state_n  = state;
        col_n    = col_idx;
        row_n    = row_idx;
        settle_n = settle_cnt;
        eval_en  = 1'b0;
        case (state)
            IDLE: begin
                col_n    = '0;
                row_n    = '0;
                settle_n = '0;
                if (scan_en) state_n = DRIVE;
            end
            DRIVE: begin
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    settle_n = '0;
                    row_n    = '0;
                    state_n  = EVAL;
                end else begin
                    settle_n = settle_cnt + SW'(1);
                end
            end
            EVAL: begin
                eval_en = 1'b1;
                if (row_idx == RW'(NROWS - 1)) begin
                    row_n = '0;
                    // Scan stops only at a column boundary, and always resumes at column 0.
                    if (!scan_en) begin
                        state_n = IDLE;
                        col_n   = '0;
                    end else begin
                        state_n = DRIVE;
                        col_n   = (col_idx == CW'(NCOLS - 1)) ? '0 : col_idx + CW'(1);
                    end
                end else begin
                    row_n = row_idx + RW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        col_out = '0;
        for (int unsigned c = 0; c < NCOLS; c++) begin
            col_out[c] = (state != IDLE) && (col_idx == CW'(c));
        end
    end

    assign cur_key = 4'(col_idx) * 4'(NROWS) + 4'(row_idx);

    always_comb begin
        sample    = 1'b0;
        cur_state = 1'b0;
        cur_cnt   = '0;
        for (int unsigned r = 0; r < NROWS; r++) begin
            if (row_idx == RW'(r)) sample = row_sync[r];
        end
        for (int unsigned k = 0; k < NKEYS; k++) begin
            if (cur_key == 4'(k)) begin
                cur_state = key_state[k];
                cur_cnt   = dbc_cnt[k];
            end
        end
    end

    assign cnt_inc = cur_cnt + 4'd1;
    assign differ  = sample ^ cur_state;
    assign push    = eval_en & differ & (cnt_inc == 4'(DEBOUNCE_SCANS));

    always_ff @(posedge CLK) begin
        if (RST) begin
            key_state <= '0;
            for (int unsigned k = 0; k < NKEYS; k++) dbc_cnt[k] <= '0;
        end else if (eval_en) begin
            for (int unsigned k = 0; k < NKEYS; k++) begin
                if (cur_key == 4'(k)) begin
                    if (!differ) begin
                        dbc_cnt[k] <= '0;
                    end else if (push) begin
                        dbc_cnt[k]   <= '0;
                        key_state[k] <= ~cur_state;
                    end else begin
                        dbc_cnt[k] <= cnt_inc;
                    end
                end
            end
        end
    end

    assign evt_valid = (fcount != '0);
    assign pop       = evt_valid & evt_ready;
    // A full FIFO still takes the new event when the head leaves on the same edge.
    assign push_ok   = push & ((fcount < NW'(FIFO_DEPTH)) | pop);

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            fifo_key[wr_ptr]   <= cur_key;
            fifo_press[wr_ptr] <= ~cur_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fcount   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   fcount <= fcount + NW'(1);
                2'b01:   fcount <= fcount - NW'(1);
                default: fcount <= fcount;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    assign evt_key   = evt_valid ? fifo_key[rd_ptr]   : 4'd0;
    assign evt_press = evt_valid ? fifo_press[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives the rows, and a
// frame-level debounce/event model predicts key_state, events and overflow.
module tb_keypad_scan_ctrl;

    localparam int NC    = 2;
    localparam int NR    = 2;
    localparam int S     = 4;
    localparam int D     = 3;
    localparam int FD    = 4;
    localparam int NK    = NC * NR;
    localparam int COLT  = S + NR;
    localparam int FRAME = NC * COLT;
    localparam int LMIN  = 2 + (D - 1) * FRAME;
    localparam int LMAX  = 2 + D * FRAME + S + NR;

    logic          CLK = 1'b0;
    logic          RST;
    logic          scan_en;
    logic [NR-1:0] row_in;
    logic [NR-1:0] row_force;
    logic [NR-1:0] keypad_rows;
    logic [NC-1:0] col_out;
    logic [NK-1:0] key_state;
    logic          evt_valid;
    logic          evt_ready;
    logic [3:0]    evt_key;
    logic          evt_press;
    logic          overflow;
    logic [NK-1:0] pressed;

    typedef struct {
        logic [3:0] key;
        logic       press;
    } ev_t;

    ev_t           expq[$];
    logic [NK-1:0] m_state;
    int            m_cnt [NK];
    logic          m_ovf;
    bit            hold_low;
    bit            rand_ready;
    bit            col_chk;
    bit            lat_arm;
    int            lat_start;
    int            lat_seen;
    int            cyc;
    int            errors;
    int            checks;

    always #5 CLK = ~CLK;

    // Physical keypad: a row reads high when a pressed key joins it to the driven column.
    always_comb begin
        keypad_rows = '0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                if (col_out[c] && pressed[c*NR + r]) keypad_rows[r] = 1'b1;
    end
    assign row_in = keypad_rows | row_force;

    keypad_scan_ctrl #(
        .NCOLS(NC),
        .NROWS(NR),
        .SETTLE_CYCLES(S),
        .DEBOUNCE_SCANS(D),
        .FIFO_DEPTH(FD)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .scan_en(scan_en),
        .row_in(row_in),
        .col_out(col_out),
        .key_state(key_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key(evt_key),
        .evt_press(evt_press),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        expq.delete();
        m_state = '0;
        m_ovf   = 1'b0;
        for (int k = 0; k < NK; k++) m_cnt[k] = 0;
    endfunction

    // One frame's look at key k: D consecutive disagreeing frames flip the stable state.
    function automatic void model_eval(input int k, input logic s);
        ev_t e;
        if (s == m_state[k]) begin
            m_cnt[k] = 0;
        end else begin
            m_cnt[k]++;
            if (m_cnt[k] == D) begin
                m_state[k] = ~m_state[k];
                m_cnt[k]   = 0;
                e.key      = 4'(k);
                e.press    = m_state[k];
                if (hold_low && expq.size() >= FD) m_ovf = 1'b1;
                else expq.push_back(e);
            end
        end
    endfunction

    task automatic tick();
        ev_t e;
        if (evt_valid && evt_ready) begin
            chk("pop_expected", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("pop_key", 32'(evt_key), 32'(e.key));
                chk("pop_press", 32'(evt_press), 32'(e.press));
            end
        end
        if (lat_arm && evt_valid) begin
            lat_seen = cyc;
            lat_arm  = 1'b0;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (rand_ready) evt_ready = (expq.size() >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    // Called at the first DRIVE cycle of column 0; leaves at the next frame's start.
    task automatic run_frame(input logic [NK-1:0] pv);
        pressed = pv;
        for (int k = 0; k < NK; k++) model_eval(k, pv[k]);
        for (int i = 0; i < FRAME; i++) begin
            if (col_chk) chk("col_out_frame", 32'(col_out), 32'(1 << (i / COLT)));
            tick();
        end
        chk("key_state", 32'(key_state), 32'(m_state));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        logic [NK-1:0] pv;
        int d;
        errors = 0; checks = 0; cyc = 0;
        hold_low = 0; rand_ready = 0; col_chk = 0; lat_arm = 0;
        lat_start = 0; lat_seen = 0;
        model_reset();
        RST = 1'b1; scan_en = 1'b0; evt_ready = 1'b0; pressed = '0; row_force = '1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_col_out", 32'(col_out), 32'd0);
        chk("rst_key_state", 32'(key_state), 32'd0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt_key", 32'(evt_key), 32'd0);
        chk("rst_evt_press", 32'(evt_press), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        RST = 1'b0; scan_en = 1'b1; row_force = '0; evt_ready = 1'b1;
        tick();
        col_chk = 1;
        repeat (2) run_frame('0);
        col_chk = 0;

        // Key 2 press and release, with press latency window.
        lat_start = cyc; lat_arm = 1'b1;
        repeat (5) run_frame(4'b0100);
        d = lat_seen - lat_start;
        checks++;
        assert (!lat_arm && d >= LMIN && d <= LMAX) else begin
            errors++;
            $error("FAIL press_latency: observed=%0d cycles (armed=%0d) required %0d..%0d",
                   d, lat_arm, LMIN, LMAX);
        end
        lat_arm = 1'b0;
        repeat (5) run_frame('0);

        // Bounce shorter than the debounce window, twice.
        repeat (2) run_frame(4'b0010);
        repeat (3) run_frame('0);
        repeat (2) run_frame(4'b0010);
        repeat (3) run_frame('0);
        chk("bounce_no_event", 32'(evt_valid), 32'd0);

        // Two keys in one column.
        repeat (4) run_frame(4'b0011);
        repeat (4) run_frame('0);

        // Random key activity with random consumer back-pressure.
        rand_ready = 1;
        pv = '0;
        repeat (30) begin
            if ($urandom_range(0, 2) == 0) pv[$urandom_range(0, NK - 1)] ^= 1'b1;
            run_frame(pv);
        end
        rand_ready = 0; evt_ready = 1'b1;
        repeat (4) run_frame('0);
        chk("random_drained_valid", 32'(evt_valid), 32'd0);
        chk("random_drained_queue", 32'(expq.size()), 32'd0);

        // Overflow: five events against a four-entry FIFO with no consumer.
        evt_ready = 1'b0; hold_low = 1;
        repeat (3) run_frame(4'b0111);
        repeat (3) run_frame(4'b0100);
        chk("full_valid", 32'(evt_valid), 32'd1);
        hold_low = 0; evt_ready = 1'b1;
        run_frame(4'b0100);
        chk("drain_valid", 32'(evt_valid), 32'd0);
        chk("drain_queue", 32'(expq.size()), 32'd0);
        chk("overflow_sticky", 32'(overflow), 32'd1);

        // scan_en dropped in column 0 DRIVE: column 0 finishes, then idle.
        scan_en = 1'b0;
        for (int k = 0; k < NR; k++) model_eval(k, pressed[k]);
        for (int i = 0; i < FRAME; i++) begin
            chk("col_out_stop", 32'(col_out), (i < COLT) ? 32'd1 : 32'd0);
            tick();
        end
        chk("stop_key_state", 32'(key_state), 32'(m_state));
        scan_en = 1'b1;
        tick();
        col_chk = 1;
        repeat (2) run_frame(4'b0100);
        col_chk = 0;

        // Reset mid-scan discards queued events and the sticky flag.
        evt_ready = 1'b0; hold_low = 1;
        repeat (3) run_frame(4'b1100);
        chk("queued_before_rst", 32'(evt_valid), 32'd1);
        RST = 1'b1; pressed = '0;
        tick();
        model_reset();
        chk("midrst_col_out", 32'(col_out), 32'd0);
        chk("midrst_key_state", 32'(key_state), 32'd0);
        chk("midrst_evt_valid", 32'(evt_valid), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        RST = 1'b0; hold_low = 0; evt_ready = 1'b1;
        tick();
        repeat (2) run_frame('0);
        chk("final_valid", 32'(evt_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
